occupancy_map: RTL
==================

# occupancy_map

Occupancy-grid store and updater directly downstream of the ray-tracing stage. It consumes the per-cell stream (`x_index`, `y_index`, `cell_is_free`, `write_enable`) and applies saturating log-odds updates to a 32 x 16 grid of signed cells with a 2-stage read-modify-write pipeline, accepting one update per cycle. It gives the scan matcher a 1-cycle-latency read port and sweeps the whole grid to zero after reset or on request.

## Interface

Parameters:
- `CELL_W`, 8: log-odds cell width, signed two's complement.
- `L_OCC`, 3: increment for an occupied hit.
- `L_FREE`, 1: decrement for a free pass.
- `L_MAX`, 127: saturation bound. Cells are clamped to [-L_MAX, +L_MAX].

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `x_index` in 5: cell column from the ray tracer.
- `y_index` in 4: cell row from the ray tracer.
- `cell_is_free` in 1: 1 applies -L_FREE, 0 applies +L_OCC.
- `write_enable` in 1: one update per cycle while high.
- `clear` in 1: single-cycle pulse that starts a full-grid zero sweep.
- `rd_en` in 1: read request.
- `rd_x` in 5: read column.
- `rd_y` in 4: read row.
- `rd_valid` out 1: high one cycle after `rd_en`.
- `rd_data` out CELL_W: signed log-odds value of the requested cell.
- `busy` out 1: high while clearing.

## Operation

- Cell address is {y, x}, 9 bits, giving 512 entries. The memory is synchronous and is not reset.
- FSM states are CLEAR and RUN.
  - `reset` enters CLEAR with the sweep counter at 0.
  - CLEAR writes 0 to address counter and increments, one address per cycle. After address 511 it goes to RUN.
  - A `clear` pulse in any state, including mid-CLEAR, goes to CLEAR with the counter at 0.
- Update pipeline, active only in RUN.
  - **S0:** on a cycle with `write_enable` = 1, register the address and `cell_is_free`, and issue the memory read.
  - **S1:** next cycle, compute new = clamp(old + delta) at CELL_W+1 bits, then write it back.
  - **Forwarding:** if the S1 address equals the address written on the previous edge, `old` is that registered written value, not the memory output. Back-to-back updates to the same cell must therefore accumulate with none lost.
- Updates while `busy` are dropped with no effect.
- On entering CLEAR, a pending S1 write is suppressed (flushed).
- Read port:
  - `rd_en` at cycle t gives `rd_valid` = 1 and `rd_data` at cycle t+1.
  - The data reflects every update accepted at cycles up to and including t-1. When the S1 write in cycle t targets the same address, its new value is bypassed into `rd_data`.
  - While `busy`, `rd_data` = 0 and `rd_valid` still follows `rd_en`.
- Arithmetic:
  - delta = -L_FREE when free, +L_OCC when occupied.
  - The sum is sign-extended by 1 bit before clamping, so it never wraps. +127 plus L_OCC stays 127, and -127 minus L_FREE stays -127.
  - The value -128 is never produced.

## Timing

- Reset values:
  - `busy` = 1.
  - `rd_valid` = 0.
  - `rd_data` = 0.
  - Pipeline valid bits = 0.
- After `reset` falls, `busy` stays high for exactly 512 cycles, then drops to 0.
- A `clear` pulse at cycle t makes `busy` = 1 from t+1 for 512 cycles. Reasserting `clear` restarts the count.
- Update latency:
  - An update at cycle t is written at the end of t+1.
  - It is visible to a read issued at t+1 through the bypass, and through memory from t+2.
- Throughput is one update and one read per cycle, simultaneously, with no stalls. There is no backpressure: upstream must not drive `write_enable` while `busy`.
- `reset` mid-update discards both pipeline stages and restarts the sweep.

## Test plan

1. **Reset sweep:** release `reset`. Require `busy` = 1 for 512 cycles, then 0. A read of (x=3, y=2) returns 0 and a read of (31, 15) returns 0.
2. **Single updates:**
   - Free update at (5, 3), then a read two cycles later: require -1.
   - Occupied update at (6, 3): a read returns 3.
3. **Back-to-back same cell:** occupied updates at (10, 7) on three consecutive cycles, then one free update. Require a read of 8, proving forwarding and no lost updates.
4. **Read bypass:** occupied update at (1, 1) at cycle t, `rd_en` at (1, 1) at t+1. Require `rd_data` = 3 at t+2.
5. **Saturation:**
   - 45 occupied updates at (0, 0): require 127.
   - 130 free updates at (0, 1): require -127, never -128.
6. **Clear mid-stream:** update (2, 2) occupied at t with `clear` at t+1. Require `busy` high from t+2, updates during `busy` ignored, and (2, 2) reading 0 once `busy` falls.

Source files
------------

// File: rtl/occupancy_map.sv
// Occupancy-grid store: 32x16 signed log-odds cells updated through a 2-stage
// read-modify-write pipeline, with a 1-cycle read port and a full-grid zero sweep.
module occupancy_map #(
  parameter int CELL_W = 8,
  parameter int L_OCC  = 3,
  parameter int L_FREE = 1,
  parameter int L_MAX  = 127
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [4:0]               x_index,
  input  logic [3:0]               y_index,
  input  logic                     cell_is_free,
  input  logic                     write_enable,
  input  logic                     clear,
  input  logic                     rd_en,
  input  logic [4:0]               rd_x,
  input  logic [3:0]               rd_y,
  output logic                     rd_valid,
  output logic signed [CELL_W-1:0] rd_data,
  output logic                     busy
);

  localparam int DEPTH = 512;

  localparam logic signed [CELL_W:0] DELTA_OCC  = (CELL_W+1)'(L_OCC);
  localparam logic signed [CELL_W:0] DELTA_FREE = -((CELL_W+1)'(L_FREE));
  localparam logic signed [CELL_W:0] SAT_HI     = (CELL_W+1)'(L_MAX);
  localparam logic signed [CELL_W:0] SAT_LO     = -SAT_HI;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [8:0]          sweepCnt_q, sweepCnt_d;
  logic                sweepWe;

  logic [CELL_W-1:0]   mem [DEPTH];

  logic                s0Accept;
  logic                s1Valid_q;
  logic [8:0]          s1Addr_q;
  logic                s1Free_q;
  logic [CELL_W-1:0]   memOld_q;
  logic                s1We;

  logic                lastWrValid_q;
  logic [8:0]          lastWrAddr_q;
  logic [CELL_W-1:0]   lastWrData_q;

  logic [CELL_W-1:0]   oldVal;
  logic signed [CELL_W:0] sum;
  logic signed [CELL_W:0] clamped;
  logic [CELL_W-1:0]   newVal;

  logic                memWe;
  logic [8:0]          memWrAddr;
  logic [CELL_W-1:0]   memWrData;

  logic [8:0]          updAddr;
  logic [8:0]          rdAddr;
  logic                rdValid_q;
  logic [CELL_W-1:0]   rdData_q;

  assign updAddr = {y_index, x_index};
  assign rdAddr  = {rd_y, rd_x};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= CLEAR;
      sweepCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sweepCnt_q <= sweepCnt_d;
    end
  end

  // A clear pulse restarts the sweep from address 0 whatever the current state.
  always_comb begin
    state_d    = state_q;
    sweepCnt_d = sweepCnt_q;
    sweepWe    = 1'b0;
    if (clear) begin
      state_d    = CLEAR;
      sweepCnt_d = '0;
    end else if (state_q == CLEAR) begin
      sweepWe    = 1'b1;
      sweepCnt_d = sweepCnt_q + 9'd1;
      if (sweepCnt_q == 9'd511) begin
        state_d = RUN;
      end
    end
  end

  assign s0Accept = write_enable && (state_q == RUN) && !clear;
  assign s1We     = s1Valid_q && (state_q == RUN) && !clear && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1Valid_q     <= 1'b0;
      lastWrValid_q <= 1'b0;
    end else begin
      s1Valid_q     <= s0Accept;
      lastWrValid_q <= s1We;
    end
  end

  // Memory read-during-write returns stale data, so the value written on the
  // previous edge is forwarded to keep back-to-back updates from being lost.
  always_comb begin
    oldVal = memOld_q;
    if (lastWrValid_q && (lastWrAddr_q == s1Addr_q)) begin
      oldVal = lastWrData_q;
    end
    sum     = $signed({oldVal[CELL_W-1], oldVal}) + (s1Free_q ? DELTA_FREE : DELTA_OCC);
    clamped = sum;
    if (sum > SAT_HI) begin
      clamped = SAT_HI;
    end else if (sum < SAT_LO) begin
      clamped = SAT_LO;
    end
    newVal = clamped[CELL_W-1:0];
  end

  assign memWe     = sweepWe || s1We;
  assign memWrAddr = sweepWe ? sweepCnt_q : s1Addr_q;
  assign memWrData = sweepWe ? '0 : newVal;

  always_ff @(posedge clock) begin
    s1Addr_q     <= updAddr;
    s1Free_q     <= cell_is_free;
    memOld_q     <= mem[updAddr];
    lastWrAddr_q <= s1Addr_q;
    lastWrData_q <= newVal;
    if (memWe) begin
      mem[memWrAddr] <= memWrData;
    end
  end

  // Read data is forced to zero around a sweep; an S1 write to the same cell
  // in the request cycle is bypassed since memory still holds the old value.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
    end else begin
      rdValid_q <= rd_en;
      if (clear || (state_q == CLEAR)) begin
        rdData_q <= '0;
      end else if (s1We && (s1Addr_q == rdAddr)) begin
        rdData_q <= newVal;
      end else begin
        rdData_q <= mem[rdAddr];
      end
    end
  end

  assign rd_valid = rdValid_q;
  assign rd_data  = rdData_q;
  assign busy     = (state_q == CLEAR);

endmodule
